// File: rtl/game_pkg.sv
// Shared game definitions: player state encoding, sprite/screen geometry
// and the vertical position helpers used by the motion controller.
package game_pkg;

   typedef enum logic [1:0] {
      GROUND = 2'd0,
      AIR    = 2'd1,
      DEAD   = 2'd2,
      WON    = 2'd3
   } pstate_t;

   localparam int PLAYER_W = 16;
   localparam int PLAYER_H = 16;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   localparam logic [9:0] X_MAX = 10'd624;
   localparam logic [9:0] Y_MAX = 10'd463;

   // y + v in 11-bit signed arithmetic, clamped to the visible range
   function automatic logic [9:0] add_clamp_y(input logic [9:0] y,
                                              input logic signed [7:0] v);
      logic signed [10:0] sum;
      sum = $signed({1'b0, y}) + $signed({{3{v[7]}}, v});
      if (sum < 11'sd0)
         return '0;
      else if (sum > $signed({1'b0, Y_MAX}))
         return Y_MAX;
      else
         return sum[9:0];
   endfunction

   // top-left y that rests the sprite on a support surface; floors at 0
   function automatic logic [9:0] snap_y(input logic [9:0] support_y);
      if (support_y < 10'(PLAYER_H))
         return '0;
      else
         return support_y - 10'(PLAYER_H);
   endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector whose history register only advances on an enable,
// so the edge is measured between consecutive enabled samples.
module edge_detect (
   input  logic clk,
   input  logic resetn,
   input  logic en,
   input  logic level,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         prev <= 1'b0;
      else if (en)
         prev <= level;
   end

   assign rise = level & ~prev;

endmodule

// File: rtl/player_physics.sv
// Frame-rate player motion controller: walking, jumping, gravity, landing,
// death/respawn and win. Optional ledge grace jump under PLAYER_COYOTE_EN.
module player_physics
   import game_pkg::*;
#(
   parameter logic [9:0]        START_X        = 10'd20,
   parameter logic [9:0]        START_Y        = 10'd344,
   parameter logic [9:0]        MOVE_SPEED     = 10'd2,
   parameter logic signed [7:0] JUMP_VEL       = 8'sd9,
   parameter logic signed [7:0] GRAVITY        = 8'sd1,
   parameter logic signed [7:0] MAX_FALL       = 8'sd8,
   parameter logic [7:0]        RESPAWN_FRAMES = 8'd60,
   parameter int                COYOTE_FRAMES  = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       frame_tick,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_jump,
   input  logic       on_ground,
   input  logic [9:0] support_y,
   input  logic       hit_ceiling,
   input  logic       hit_left_wall,
   input  logic       hit_right_wall,
   input  logic       at_goal_region,
   input  logic       in_lava,
   output logic [9:0] player_x,
   output logic [9:0] player_y,
   output logic [1:0] pstate,
   output logic       died_pulse,
   output logic       won_pulse,
   output logic       update_done
);

   pstate_t           state_q, state_d;
   logic [9:0]        x_q, x_d, y_q, y_d, walk_x;
   logic signed [7:0] vel_q, vel_d, vel_fall;
   logic [7:0]        cnt_q, cnt_d;
   logic              died_d, won_d, jump_edge;

`ifdef PLAYER_COYOTE_EN
   localparam int COY_W = $clog2(COYOTE_FRAMES + 1);
   logic [COY_W-1:0] coy_q, coy_d;
`endif

   edge_detect u_jump_edge (
      .clk    (clk),
      .resetn (resetn),
      .en     (frame_tick),
      .level  (btn_jump),
      .rise   (jump_edge)
   );

   always_comb begin
      walk_x = x_q;
      if (btn_left && !btn_right && !hit_left_wall)
         walk_x = (x_q < MOVE_SPEED) ? '0 : x_q - MOVE_SPEED;
      else if (btn_right && !btn_left && !hit_right_wall)
         walk_x = (x_q > X_MAX - MOVE_SPEED) ? X_MAX : x_q + MOVE_SPEED;
   end

   // Ceiling contact kills upward speed; otherwise accelerate toward MAX_FALL.
   always_comb begin
      vel_fall = vel_q + GRAVITY;
      if (hit_ceiling && vel_q[7])
         vel_fall = '0;
      else if (vel_fall > MAX_FALL)
         vel_fall = MAX_FALL;
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      vel_d   = vel_q;
      cnt_d   = cnt_q;
      died_d  = 1'b0;
      won_d   = 1'b0;
`ifdef PLAYER_COYOTE_EN
      coy_d   = coy_q;
`endif
      case (state_q)
         GROUND, AIR: begin
            if (in_lava) begin
               state_d = DEAD;
               vel_d   = '0;
               cnt_d   = '0;
               died_d  = 1'b1;
`ifdef PLAYER_COYOTE_EN
               coy_d   = '0;
`endif
            end else if (at_goal_region) begin
               state_d = WON;
               won_d   = 1'b1;
            end else begin
               x_d = walk_x;
               if (state_q == GROUND) begin
                  if (jump_edge) begin
                     vel_d   = -JUMP_VEL;
                     y_d     = add_clamp_y(y_q, -JUMP_VEL);
                     state_d = AIR;
`ifdef PLAYER_COYOTE_EN
                     coy_d   = '0;
`endif
                  end else if (!on_ground) begin
                     vel_d   = '0;
                     state_d = AIR;
`ifdef PLAYER_COYOTE_EN
                     coy_d   = COY_W'(COYOTE_FRAMES);
`endif
                  end else begin
                     y_d = snap_y(support_y);
                  end
               end else if (on_ground && !vel_q[7]) begin
                  y_d     = snap_y(support_y);
                  vel_d   = '0;
                  state_d = GROUND;
`ifdef PLAYER_COYOTE_EN
                  coy_d   = '0;
`endif
`ifdef PLAYER_COYOTE_EN
               end else if (jump_edge && coy_q != '0) begin
                  vel_d = -JUMP_VEL;
                  y_d   = add_clamp_y(y_q, -JUMP_VEL);
                  coy_d = '0;
`endif
               end else begin
                  vel_d = vel_fall;
                  y_d   = add_clamp_y(y_q, vel_fall);
`ifdef PLAYER_COYOTE_EN
                  if (coy_q != '0)
                     coy_d = coy_q - COY_W'(1);
`endif
               end
            end
         end
         DEAD: begin
            if (cnt_q == RESPAWN_FRAMES - 8'd1) begin
               x_d     = START_X;
               y_d     = START_Y;
               vel_d   = '0;
               cnt_d   = '0;
               state_d = GROUND;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= GROUND;
         x_q         <= START_X;
         y_q         <= START_Y;
         vel_q       <= '0;
         cnt_q       <= '0;
         died_pulse  <= 1'b0;
         won_pulse   <= 1'b0;
         update_done <= 1'b0;
`ifdef PLAYER_COYOTE_EN
         coy_q       <= '0;
`endif
      end else begin
         update_done <= frame_tick;
         died_pulse  <= frame_tick & died_d;
         won_pulse   <= frame_tick & won_d;
         if (frame_tick) begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            cnt_q   <= cnt_d;
`ifdef PLAYER_COYOTE_EN
            coy_q   <= coy_d;
`endif
         end
      end
   end

   assign player_x = x_q;
   assign player_y = y_q;
   assign pstate   = state_q;

endmodule

// File: tb/tb_player_physics.sv
// Directed bench for player_physics: reset, jump arc, walking limits,
// ceiling, landing snap, ledge walk-off, death/respawn, win and reset.
module tb_player_physics;

   logic       clk = 1'b0;
   logic       resetn;
   logic       frame_tick, btn_left, btn_right, btn_jump;
   logic       on_ground, hit_ceiling, hit_left_wall, hit_right_wall;
   logic       at_goal_region, in_lava;
   logic [9:0] support_y;
   logic [9:0] player_x, player_y;
   logic [1:0] pstate;
   logic       died_pulse, won_pulse, update_done;

   int n_checks = 0;
   int n_fail   = 0;

   // y after each AIR tick following a ground jump from y=344
   int jump_y [0:16] = '{327, 320, 314, 309, 305, 302, 300, 299, 299,
                         300, 302, 305, 309, 314, 320, 327, 335};

   always #5 clk = ~clk;

   player_physics dut (
      .clk            (clk),
      .resetn         (resetn),
      .frame_tick     (frame_tick),
      .btn_left       (btn_left),
      .btn_right      (btn_right),
      .btn_jump       (btn_jump),
      .on_ground      (on_ground),
      .support_y      (support_y),
      .hit_ceiling    (hit_ceiling),
      .hit_left_wall  (hit_left_wall),
      .hit_right_wall (hit_right_wall),
      .at_goal_region (at_goal_region),
      .in_lava        (in_lava),
      .player_x       (player_x),
      .player_y       (player_y),
      .pstate         (pstate),
      .died_pulse     (died_pulse),
      .won_pulse      (won_pulse),
      .update_done    (update_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // one frame tick; returns on the falling edge after the update
   task automatic do_tick();
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic land_bounded(input string tag);
      int n;
      n = 0;
      on_ground = 1'b1;
      support_y = 10'd360;
      while (pstate != 2'd0 && n < 40) begin
         do_tick();
         n++;
      end
      check({tag, "_state"}, pstate, 2'd0);
      check({tag, "_y"}, player_y, 344);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      frame_tick = 0; btn_left = 0; btn_right = 0; btn_jump = 0;
      on_ground = 0; hit_ceiling = 0; hit_left_wall = 0; hit_right_wall = 0;
      at_goal_region = 0; in_lava = 0; support_y = 10'd0;
      repeat (3) @(negedge clk);
      check("rst_x", player_x, 20);
      check("rst_y", player_y, 344);
      check("rst_state", pstate, 0);
      check("rst_done", update_done, 0);
      check("rst_died", died_pulse, 0);
      resetn = 1'b1;

      // first frame on solid ground
      on_ground = 1'b1; support_y = 10'd360;
      do_tick();
      check("gnd_y", player_y, 344);
      check("gnd_state", pstate, 0);
      check("gnd_done", update_done, 1);
      @(negedge clk);
      check("gnd_done_clr", update_done, 0);

      // jump arc, button held the whole time
      btn_jump = 1'b1;
      do_tick();
      check("jump_y0", player_y, 335);
      check("jump_state", pstate, 1);
      on_ground = 1'b0;
      for (int i = 0; i < 17; i++) begin
         do_tick();
         check($sformatf("jump_y%0d", i + 1), player_y, jump_y[i]);
      end
      do_tick();
      check("fall_cap_y", player_y, 343);
      on_ground = 1'b1;
      do_tick();
      check("land_y", player_y, 344);
      check("land_state", pstate, 0);
      do_tick();
      check("held_no_rejump_y", player_y, 344);
      check("held_no_rejump_st", pstate, 0);
      btn_jump = 1'b0;

      // walk left to the screen edge
      btn_left = 1'b1;
      for (int i = 0; i < 10; i++) begin
         do_tick();
         check($sformatf("left_x%0d", i), player_x, 18 - 2 * i);
      end
      do_tick();
      check("left_sat_x", player_x, 0);
      btn_left = 1'b0; btn_right = 1'b1; hit_right_wall = 1'b1;
      do_tick();
      check("right_wall_x", player_x, 0);
      btn_left = 1'b1; hit_right_wall = 1'b0;
      do_tick();
      check("both_btn_x", player_x, 0);
      btn_left = 1'b0;
      repeat (315) do_tick();
      check("right_sat_x", player_x, 624);
      btn_right = 1'b0; btn_left = 1'b1; hit_left_wall = 1'b1;
      do_tick();
      check("left_wall_x", player_x, 624);
      hit_left_wall = 1'b0;
      do_tick();
      check("left_step_x", player_x, 622);
      btn_left = 1'b0;

      // ceiling bump while rising at -5
      btn_jump = 1'b1;
      do_tick();
      btn_jump = 1'b0; on_ground = 1'b0;
      repeat (4) do_tick();
      check("pre_ceil_y", player_y, 309);
      hit_ceiling = 1'b1;
      do_tick();
      check("ceil_y", player_y, 309);
      hit_ceiling = 1'b0;
      do_tick();
      check("post_ceil_y", player_y, 310);
      land_bounded("ceil_land");

      // snap with support above row 16 floors at 0
      support_y = 10'd10;
      do_tick();
      check("snap_low_y", player_y, 0);
      support_y = 10'd360;
      do_tick();
      check("snap_back_y", player_y, 344);

      // walk off a ledge, jump edge on the third AIR tick
      on_ground = 1'b0;
      do_tick();
      check("walkoff_state", pstate, 1);
      check("walkoff_y", player_y, 344);
      do_tick();
      do_tick();
      check("walkoff_fall_y", player_y, 347);
      btn_jump = 1'b1;
      do_tick();
`ifdef PLAYER_COYOTE_EN
      check("coyote_y", player_y, 338);
`else
      check("no_coyote_y", player_y, 350);
`endif
      btn_jump = 1'b0;
      land_bounded("coyote_land");

      // lava and goal together: death wins
      in_lava = 1'b1; at_goal_region = 1'b1;
      do_tick();
      check("dead_state", pstate, 2);
      check("dead_pulse", died_pulse, 1);
      check("dead_no_won", won_pulse, 0);
      check("dead_x", player_x, 622);
      check("dead_y", player_y, 344);
      in_lava = 1'b0; at_goal_region = 1'b0;
      @(negedge clk);
      check("dead_pulse_clr", died_pulse, 0);
      repeat (59) do_tick();
      check("dead_59_state", pstate, 2);
      do_tick();
      check("respawn_state", pstate, 0);
      check("respawn_x", player_x, 20);
      check("respawn_y", player_y, 344);

      // win is absorbing
      at_goal_region = 1'b1;
      do_tick();
      check("won_state", pstate, 3);
      check("won_pulse", won_pulse, 1);
      check("won_no_died", died_pulse, 0);
      at_goal_region = 1'b0; in_lava = 1'b1; btn_right = 1'b1;
      do_tick();
      check("won_hold_state", pstate, 3);
      check("won_hold_died", died_pulse, 0);
      check("won_hold_x", player_x, 20);
      in_lava = 1'b0;

      // asynchronous reset mid-frame, while update_done is high
      do_tick();
      check("pre_rst_done", update_done, 1);
      #2;
      resetn = 1'b0;
      #1;
      check("async_rst_state", pstate, 0);
      check("async_rst_done", update_done, 0);
      check("async_rst_x", player_x, 20);
      @(negedge clk);
      resetn = 1'b1;

      // back-to-back frame ticks, walking right
      on_ground = 1'b1; support_y = 10'd360; btn_right = 1'b1;
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      check("b2b_x1", player_x, 22);
      check("b2b_done1", update_done, 1);
      @(negedge clk);
      frame_tick = 1'b0;
      check("b2b_x2", player_x, 24);
      check("b2b_done2", update_done, 1);
      @(negedge clk);
      check("b2b_done_clr", update_done, 0);
      btn_right = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
